// File: rtl/if_pc_queue.sv
// if_pc_queue
// In-order queue of outstanding instruction-fetch PCs between the fetch address stage and decode.
// Each returning instruction is paired with the PC that requested it. Memory latency may span
// several cycles with several fetches outstanding. On a flush the queued entries are dropped.
// Responses already in flight for those stale requests are counted and silently discarded.
//
// Ports:
//   clk, rst      clock; synchronous active-high reset
//   req_fire_i    fetch request accepted by memory this cycle, with its PC on req_pc_i
//   req_ready_o   queue can take a new request (live + discard-pending < DEPTH)
//   resp_valid_i  memory returns one instruction on resp_inst_i, strictly in request order
//   flush_i       branch taken / pipeline flush (priority over push, response and pop)
//   stall_i       decode cannot accept this cycle; head is held
//   out_valid_o   out_pc_o / out_inst_o carry the head pair (both zero when not valid)
//   count_o       live entries in the queue
//
// Configuration:
//   IF_PCQ_BYPASS_EN  When defined, a response for the head entry is forwarded to the outputs in
//                     the same cycle (zero response-to-output latency). When undefined, the
//                     outputs come only from registered done bits (one-cycle latency).

module if_pc_queue #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned INST_WIDTH = 32,
    parameter int unsigned DEPTH      = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_fire_i,
    input  logic [ADDR_WIDTH-1:0]    req_pc_i,
    output logic                     req_ready_o,
    input  logic                     resp_valid_i,
    input  logic [INST_WIDTH-1:0]    resp_inst_i,
    input  logic                     flush_i,
    input  logic                     stall_i,
    output logic                     out_valid_o,
    output logic [ADDR_WIDTH-1:0]    out_pc_o,
    output logic [INST_WIDTH-1:0]    out_inst_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned IW = $clog2(DEPTH);
    localparam int unsigned PW = IW + 1;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [PW-1:0]         head_q, resp_ptr_q, tail_q;
    logic [PW-1:0]         discard_q;
    logic [ADDR_WIDTH-1:0] pc_q   [DEPTH];
    logic [INST_WIDTH-1:0] inst_q [DEPTH];
    logic [DEPTH-1:0]      done_q, done_d;

    logic [IW-1:0] head_idx, resp_idx, tail_idx;
    logic [PW-1:0] count, pending;
    logic [PW:0]   occupancy;
    logic [PW:0]   discard_flush;
    logic          resp_take, resp_drop;
    logic          head_done, bypass, out_valid, pop;

    assign head_idx = head_q[IW-1:0];
    assign resp_idx = resp_ptr_q[IW-1:0];
    assign tail_idx = tail_q[IW-1:0];

    assign count   = tail_q - head_q;
    assign pending = tail_q - resp_ptr_q;

    assign occupancy   = {1'b0, count} + {1'b0, discard_q};
    assign req_ready_o = occupancy < (PW + 1)'(DEPTH);

    // Stale responses are consumed first; only a clean response writes an entry.
    assign resp_drop = resp_valid_i && (discard_q != '0);
    assign resp_take = resp_valid_i && (discard_q == '0) && !flush_i;

    assign head_done = done_q[head_idx] && (count != '0);

`ifdef IF_PCQ_BYPASS_EN
    // resp_ptr == head means the head is still waiting, so this response belongs to it.
    assign bypass = resp_take && (resp_ptr_q == head_q) && (count != '0);
`else
    assign bypass = 1'b0;
`endif

    assign out_valid = !flush_i && (head_done || bypass);
    assign pop       = out_valid && !stall_i;

    assign out_valid_o = out_valid;
    assign out_pc_o    = out_valid ? pc_q[head_idx] : '0;
    assign out_inst_o  = !out_valid ? '0 : (bypass ? resp_inst_i : inst_q[head_idx]);
    assign count_o     = count;

    // A flush turns every still-pending request into a discard slot. A same-cycle response
    // retires the oldest in-flight slot, and a same-cycle fire is already stale.
    assign discard_flush = {1'b0, discard_q} + {1'b0, pending} + (PW + 1)'(req_fire_i)
                         - (PW + 1)'(resp_valid_i);

    always_comb begin
        done_d = done_q;
        // A bypassed and immediately popped entry never needs its done bit.
        if (resp_take && !(bypass && pop)) begin
            done_d[resp_idx] = 1'b1;
        end
        if (pop) begin
            done_d[head_idx] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q     <= '0;
            resp_ptr_q <= '0;
            tail_q     <= '0;
            discard_q  <= '0;
            done_q     <= '0;
        end else if (flush_i) begin
            head_q     <= tail_q;
            resp_ptr_q <= tail_q;
            done_q     <= '0;
            discard_q  <= discard_flush[PW-1:0];
        end else begin
            if (req_fire_i) begin
                tail_q <= tail_q + 1'b1;
            end
            if (resp_drop) begin
                discard_q <= discard_q - 1'b1;
            end
            if (resp_take) begin
                resp_ptr_q <= resp_ptr_q + 1'b1;
            end
            if (pop) begin
                head_q <= head_q + 1'b1;
            end
            done_q <= done_d;
        end
    end

    // Payload storage needs no reset; validity lives in the pointers and done bits.
    always_ff @(posedge clk) begin
        if (req_fire_i && !flush_i) begin
            pc_q[tail_idx] <= req_pc_i;
        end
        if (resp_take) begin
            inst_q[resp_idx] <= resp_inst_i;
        end
    end

    // Memory must only fire when there is room, and must only respond to outstanding requests.
    a_fire_when_ready : assert property (@(posedge clk) disable iff (rst)
        req_fire_i |-> req_ready_o);
    a_resp_outstanding : assert property (@(posedge clk) disable iff (rst)
        resp_valid_i |-> ((discard_q != '0) || (pending != '0)));

endmodule

// File: tb/tb_if_pc_queue.sv
module tb_if_pc_queue;

    localparam int DEPTH = 4;
`ifdef IF_PCQ_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        req_fire_i;
    logic [31:0] req_pc_i;
    logic        req_ready_o;
    logic        resp_valid_i;
    logic [31:0] resp_inst_i;
    logic        flush_i;
    logic        stall_i;
    logic        out_valid_o;
    logic [31:0] out_pc_o;
    logic [31:0] out_inst_o;
    logic [2:0]  count_o;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always #5 clk = ~clk;

    if_pc_queue #(
        .ADDR_WIDTH(32),
        .INST_WIDTH(32),
        .DEPTH     (DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_fire_i  (req_fire_i),
        .req_pc_i    (req_pc_i),
        .req_ready_o (req_ready_o),
        .resp_valid_i(resp_valid_i),
        .resp_inst_i (resp_inst_i),
        .flush_i     (flush_i),
        .stall_i     (stall_i),
        .out_valid_o (out_valid_o),
        .out_pc_o    (out_pc_o),
        .out_inst_o  (out_inst_o),
        .count_o     (count_o)
    );

    // Model: the outstanding fetches in request order, each with its instruction once it has
    // returned, plus the number of stale responses still to be swallowed.
    logic [31:0] m_pc   [$];
    logic [31:0] m_inst [$];
    bit          m_done [$];
    int          m_disc = 0;

    function automatic int m_ndone();
        int n = 0;
        foreach (m_done[i]) if (m_done[i]) n++;
        return n;
    endfunction

    task automatic model_out(output bit v, output logic [31:0] pc, output logic [31:0] inst);
        v = 1'b0; pc = '0; inst = '0;
        if (!flush_i && m_pc.size() > 0) begin
            if (m_done[0]) begin
                v = 1'b1; pc = m_pc[0]; inst = m_inst[0];
            end else if (BYP && resp_valid_i && m_disc == 0) begin
                v = 1'b1; pc = m_pc[0]; inst = resp_inst_i;
            end
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h want %h", name, cyc, act, exp);
        end
    endtask

    task automatic model_update();
        bit v; logic [31:0] p, i; int nd;
        model_out(v, p, i);
        nd = m_ndone();
        if (rst) begin
            m_pc.delete(); m_inst.delete(); m_done.delete(); m_disc = 0;
        end else if (flush_i) begin
            m_disc = m_disc + (m_pc.size() - nd) + int'(req_fire_i) - int'(resp_valid_i);
            m_pc.delete(); m_inst.delete(); m_done.delete();
        end else begin
            if (resp_valid_i) begin
                if (m_disc > 0) m_disc--;
                else if (nd < m_pc.size()) begin
                    m_inst[nd] = resp_inst_i; m_done[nd] = 1'b1;
                end
            end
            if (v && !stall_i) begin
                void'(m_pc.pop_front()); void'(m_inst.pop_front()); void'(m_done.pop_front());
            end
            if (req_fire_i) begin
                m_pc.push_back(req_pc_i); m_inst.push_back('0); m_done.push_back(1'b0);
            end
        end
    endtask

    task automatic compare();
        bit v; logic [31:0] p, i;
        model_out(v, p, i);
        check("m_out_valid", 32'(out_valid_o), 32'(v));
        check("m_out_pc", out_pc_o, p);
        check("m_out_inst", out_inst_o, i);
        check("m_count", 32'(count_o), 32'(m_pc.size()));
        check("m_ready", 32'(req_ready_o), 32'((m_pc.size() + m_disc) < DEPTH));
    endtask

    // One clock: update the model at the edge, drive new inputs, compare at the falling edge.
    task automatic step(input bit r, input bit f, input logic [31:0] pc, input bit rv,
                        input logic [31:0] ri, input bit fl, input bit st);
        @(posedge clk);
        model_update();
        #1;
        rst = r; req_fire_i = f; req_pc_i = pc; resp_valid_i = rv; resp_inst_i = ri;
        flush_i = fl; stall_i = st;
        @(negedge clk);
        cyc++;
        compare();
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic fire(input logic [31:0] pc);
        step(0, 1, pc, 0, 0, 0, 0);
    endtask

    task automatic resp(input logic [31:0] inst);
        step(0, 0, 0, 1, inst, 0, 0);
    endtask

    task automatic lit(input string name, input bit v, input logic [31:0] pc,
                       input logic [31:0] inst);
        check({name, "_valid"}, 32'(out_valid_o), 32'(v));
        check({name, "_pc"}, out_pc_o, pc);
        check({name, "_inst"}, out_inst_o, inst);
    endtask

    task automatic lit_cnt(input string name, input int cnt, input bit rdy);
        check({name, "_count"}, 32'(count_o), 32'(cnt));
        check({name, "_ready"}, 32'(req_ready_o), 32'(rdy));
    endtask

    initial begin
        rst = 1'b1; req_fire_i = 0; req_pc_i = 0; resp_valid_i = 0; resp_inst_i = 0;
        flush_i = 0; stall_i = 0;
        @(posedge clk);

        // Reset state
        idle();
        lit("reset", 0, 0, 0);
        lit_cnt("reset", 0, 1);

        // In-order pairing of three fetches
        fire(32'h1c000000); fire(32'h1c000004); fire(32'h1c000008);
        resp(32'h11);
        lit("t1_c3", BYP, BYP ? 32'h1c000000 : 0, BYP ? 32'h11 : 0);
        resp(32'h22);
        lit("t1_c4", 1, BYP ? 32'h1c000004 : 32'h1c000000, BYP ? 32'h22 : 32'h11);
        resp(32'h33);
        lit("t1_c5", 1, BYP ? 32'h1c000008 : 32'h1c000004, BYP ? 32'h33 : 32'h22);
        idle();
        lit("t1_c6", !BYP, BYP ? 0 : 32'h1c000008, BYP ? 0 : 32'h33);
        idle();
        lit("t1_c7", 0, 0, 0);
        lit_cnt("t1_c7", 0, 1);

        // Full queue blocks requests until one entry drains
        fire(32'h200); fire(32'h204); fire(32'h208); fire(32'h20c);
        idle();
        lit_cnt("t2_full", 4, 0);
        resp(32'ha0);
        lit_cnt("t2_resp", 4, 0);
        idle();
        check("t2_ready_c6", 32'(req_ready_o), 32'(BYP));
        idle();
        lit_cnt("t2_after_pop", 3, 1);
        resp(32'hb1); resp(32'hb2); resp(32'hb3); idle(); idle();

        // Flush with one done and two pending entries
        fire(32'h300); fire(32'h304); fire(32'h308);
        step(0, 0, 0, 1, 32'hc0, 0, 1);
        step(0, 0, 0, 0, 0, 1, 0);
        lit("t3_flush", 0, 0, 0);
        idle();
        lit_cnt("t3_after_flush", 0, 1);
        check("t3_model_disc", 32'(m_disc), 32'd2);
        resp(32'hd1);
        lit("t3_drop1", 0, 0, 0);
        resp(32'hd2);
        lit("t3_drop2", 0, 0, 0);
        fire(32'h1c000100);
        resp(32'haa);
        lit("t3_c8", BYP, BYP ? 32'h1c000100 : 0, BYP ? 32'haa : 0);
        idle();
        lit("t3_c9", !BYP, BYP ? 0 : 32'h1c000100, BYP ? 0 : 32'haa);
        idle();

        // Stall holds the head pair
        fire(32'h400);
        step(0, 0, 0, 1, 32'h44, 0, 1);
        step(0, 0, 0, 0, 0, 0, 1);
        lit("t4_stall2", 1, 32'h400, 32'h44);
        lit_cnt("t4_stall2", 1, 1);
        step(0, 0, 0, 0, 0, 0, 1);
        lit("t4_stall3", 1, 32'h400, 32'h44);
        idle();
        lit("t4_release", 1, 32'h400, 32'h44);
        idle();
        lit("t4_popped", 0, 0, 0);
        lit_cnt("t4_popped", 0, 1);

        // Flush, response and fire in the same cycle
        fire(32'h500); fire(32'h504);
        step(0, 1, 32'h508, 1, 32'h55, 1, 0);
        lit("t5_flush", 0, 0, 0);
        idle();
        lit_cnt("t5_after", 0, 1);
        check("t5_model_disc", 32'(m_disc), 32'd2);
        resp(32'h56); resp(32'h57);
        lit("t5_drop", 0, 0, 0);
        idle();

        // Reset in the middle of traffic clears the discard budget too
        fire(32'h600);
        step(0, 0, 0, 0, 0, 1, 0);
        fire(32'h604); fire(32'h608); fire(32'h60c);
        idle();
        lit_cnt("t6_pre_rst", 3, 0);
        check("t6_model_disc", 32'(m_disc), 32'd1);
        step(1, 0, 0, 0, 0, 0, 0);
        fire(32'h700);
        lit("t6_post_rst", 0, 0, 0);
        lit_cnt("t6_post_rst", 0, 1);
        fire(32'h704); fire(32'h708); fire(32'h70c);
        lit_cnt("t6_no_stale_disc", 3, 1);
        resp(32'h70); resp(32'h71); resp(32'h72); resp(32'h73);
        idle(); idle(); idle();
        lit_cnt("final", 0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
